// File: rtl/cpu_types_pkg.sv
// Shared CPU bring-up types.
//   aluop_t       : 4-bit ALU opcode as seen on the ALU operand ports.
//   entry_state_t : operand-entry FSM state, also shown on LEDG.
//   KEY_*         : push-button roles on the operand entry board.
package cpu_types_pkg;

  typedef logic [3:0] aluop_t;

  localparam aluop_t ALU_ADD = 4'h0;
  localparam aluop_t ALU_SUB = 4'h1;
  localparam aluop_t ALU_AND = 4'h2;
  localparam aluop_t ALU_OR  = 4'h3;
  localparam aluop_t ALU_XOR = 4'h4;
  localparam aluop_t ALU_SLT = 4'h5;

  typedef enum logic [1:0] {
    ENTER_A  = 2'd0,
    ENTER_B  = 2'd1,
    ENTER_OP = 2'd2,
    ISSUE    = 2'd3
  } entry_state_t;

  localparam int unsigned KEY_LO   = 0;
  localparam int unsigned KEY_HI   = 1;
  localparam int unsigned KEY_NEXT = 2;
  localparam int unsigned KEY_CLR  = 3;

endpackage

// File: rtl/alu_operand_entry_if.sv
// Operand bundle between the entry block (master) and the ALU (slave).
//   porta, portb : operands
//   aluop        : opcode
//   op_valid     : operand set complete, held until accepted
//   op_ready     : consumer accepts when op_valid && op_ready
interface alu_operand_entry_if #(
  parameter int WIDTH = 32
);
  import cpu_types_pkg::*;

  logic [WIDTH-1:0] porta;
  logic [WIDTH-1:0] portb;
  aluop_t           aluop;
  logic             op_valid;
  logic             op_ready;

  modport master (output porta, output portb, output aluop, output op_valid,
                  input  op_ready);
  modport slave  (input  porta, input  portb, input  aluop, input  op_valid,
                  output op_ready);

endinterface

// File: rtl/alu_operand_entry_key_debounce.sv
// One push-button: 2-flop synchronizer, stability counter and press pulse.
//   clk_i, rst_i : clock, async active-high reset
//   key_n_i      : raw active-low button
//   press_o      : one-cycle pulse when the accepted level goes 1 -> 0
module key_debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic press_o
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [1:0]    vld_q;
  logic          level_q;
  logic          arm_q;
  logic          press_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          accept;

  // accept fires on the DB_CYCLES-th consecutive sample that disagrees
  always_comb begin
    cnt_d  = '0;
    accept = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) accept = 1'b1;
      else                   cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= 2'b11;
      vld_q   <= 2'b00;
      level_q <= 1'b1;
      arm_q   <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], key_n_i};
      vld_q   <= {vld_q[0], 1'b1};
      // Only arm once a genuine released sample has come through the
      // synchronizer, so a key held across reset never produces a press.
      arm_q   <= arm_q | (vld_q[1] & sync_q[1]);
      cnt_q   <= cnt_d;
      press_q <= 1'b0;
      if (accept) begin
        level_q <= sync_q[1];
        press_q <= arm_q & ~sync_q[1];
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/alu_operand_entry.sv
// Board-side operand entry: debounced keys and switches build two operands
// and an opcode, then offer them to the ALU via valid/ready.
//   CLK, RST : clock, async active-high reset
//   key_n    : raw buttons (KEY0 low half, KEY1 high half, KEY2 next, KEY3 clear)
//   sw       : raw slide switches, data for the half-word loads
//   opif     : operand bundle (master side)
//   state_o  : current entry_state_t, for LEDG
module alu_operand_entry
  import cpu_types_pkg::*;
#(
  parameter int DB_CYCLES = 500000,
  parameter int WIDTH     = 32
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [3:0]                 key_n,
  input  logic [15:0]                sw,
  alu_operand_entry_if.master        opif,
  output logic [1:0]                 state_o
);

  localparam int HALF = WIDTH / 2;

  logic [3:0]       key_press;
  logic [15:0]      sw_meta_q;
  logic [15:0]      sw_s_q;
  entry_state_t     state_q;
  logic [WIDTH-1:0] porta_q;
  logic [WIDTH-1:0] portb_q;
  aluop_t           aluop_q;
  logic             op_valid_q;

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_key (
      .clk_i   (CLK),
      .rst_i   (RST),
      .key_n_i (key_n[i]),
      .press_o (key_press[i])
    );
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sw_meta_q <= '0;
      sw_s_q    <= '0;
    end else begin
      sw_meta_q <= sw;
      sw_s_q    <= sw_meta_q;
    end
  end

  // op_valid is registered alongside the state so it is high exactly while
  // state_q == ISSUE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ENTER_A;
      porta_q    <= '0;
      portb_q    <= '0;
      aluop_q    <= '0;
      op_valid_q <= 1'b0;
    end else if (key_press[KEY_CLR]) begin
      state_q    <= ENTER_A;
      porta_q    <= '0;
      portb_q    <= '0;
      aluop_q    <= '0;
      op_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ENTER_A: begin
          if (key_press[KEY_LO])   porta_q[HALF-1:0]     <= sw_s_q;
          if (key_press[KEY_HI])   porta_q[WIDTH-1:HALF] <= sw_s_q;
          if (key_press[KEY_NEXT]) state_q <= ENTER_B;
        end
        ENTER_B: begin
          if (key_press[KEY_LO])   portb_q[HALF-1:0]     <= sw_s_q;
          if (key_press[KEY_HI])   portb_q[WIDTH-1:HALF] <= sw_s_q;
          if (key_press[KEY_NEXT]) state_q <= ENTER_OP;
        end
        ENTER_OP: begin
          if (key_press[KEY_LO]) aluop_q <= sw_s_q[3:0];
          if (key_press[KEY_NEXT]) begin
            state_q    <= ISSUE;
            op_valid_q <= 1'b1;
          end
        end
        ISSUE: begin
          if (op_valid_q && opif.op_ready) begin
            state_q    <= ENTER_A;
            op_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= ENTER_A;
          op_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign opif.porta    = porta_q;
  assign opif.portb    = portb_q;
  assign opif.aluop    = aluop_q;
  assign opif.op_valid = op_valid_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_alu_operand_entry.sv
// Bench for alu_operand_entry with a short debounce window.
module tb_alu_operand_entry;
  import cpu_types_pkg::*;

  localparam int DB = 4;
  localparam int HOLD = 12;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  key_n = 4'hF;
  logic [15:0] sw = '0;
  logic [1:0]  state_o;

  alu_operand_entry_if #(.WIDTH(32)) opif ();

  alu_operand_entry #(.DB_CYCLES(DB), .WIDTH(32)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .key_n   (key_n),
    .sw      (sw),
    .opif    (opif),
    .state_o (state_o)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;
  int pulse2 = 0;

  always @(negedge CLK) if (dut.key_press[2]) pulse2++;

  typedef struct {
    string       tag;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [1:0]  st;
    logic        v;
  } exp_t;

  exp_t sb[$];

  logic [31:0] m_a, m_b;
  logic [3:0]  m_op;
  logic [1:0]  m_st;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_a = '0; m_b = '0; m_op = '0; m_st = 2'd0;
  endtask

  task automatic model_keys(input logic [3:0] k, input logic [15:0] s);
    if (k[3]) begin
      model_reset();
    end else begin
      case (m_st)
        2'd0: begin
          if (k[0]) m_a[15:0]  = s;
          if (k[1]) m_a[31:16] = s;
          if (k[2]) m_st = 2'd1;
        end
        2'd1: begin
          if (k[0]) m_b[15:0]  = s;
          if (k[1]) m_b[31:16] = s;
          if (k[2]) m_st = 2'd2;
        end
        2'd2: begin
          if (k[0]) m_op = s[3:0];
          if (k[2]) m_st = 2'd3;
        end
        default: ;
      endcase
    end
  endtask

  task automatic push_exp(input string tag);
    exp_t e;
    e.tag = tag; e.a = m_a; e.b = m_b; e.op = m_op; e.st = m_st;
    e.v = (m_st == 2'd3);
    sb.push_back(e);
  endtask

  task automatic check_sb();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL sb_empty: got 0 entries want 1");
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".a"},  opif.porta, e.a);
      chk({e.tag, ".b"},  opif.portb, e.b);
      chk({e.tag, ".op"}, {28'd0, opif.aluop}, {28'd0, e.op});
      chk({e.tag, ".st"}, {30'd0, state_o}, {30'd0, e.st});
      chk({e.tag, ".v"},  {31'd0, opif.op_valid}, {31'd0, e.v});
    end
  endtask

  task automatic press(input logic [3:0] k, input logic [15:0] s, input string tag);
    @(negedge CLK);
    sw = s;
    repeat (3) @(negedge CLK);
    model_keys(k, s);
    push_exp(tag);
    key_n = key_n & ~k;
    repeat (HOLD) @(negedge CLK);
    key_n = key_n | k;
    repeat (HOLD) @(negedge CLK);
    check_sb();
  endtask

  initial begin
    int waited;
    opif.op_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    chk("rst.a",  opif.porta, 32'h0);
    chk("rst.b",  opif.portb, 32'h0);
    chk("rst.op", {28'd0, opif.aluop}, 32'h0);
    chk("rst.v",  {31'd0, opif.op_valid}, 32'h0);
    chk("rst.st", {30'd0, state_o}, 32'h0);

    // bouncing KEY2 then a solid press
    pulse2 = 0;
    for (int i = 0; i < 10; i++) begin
      key_n[2] = 1'b0; repeat (2) @(negedge CLK);
      key_n[2] = 1'b1; repeat (2) @(negedge CLK);
    end
    chk("bounce.none", pulse2, 0);
    key_n[2] = 1'b0;
    repeat (HOLD) @(negedge CLK);
    key_n[2] = 1'b1;
    repeat (HOLD) @(negedge CLK);
    chk("bounce.pulses", pulse2, 1);
    chk("bounce.st", {30'd0, state_o}, 32'd1);
    m_st = 2'd1;

    // 3-cycle glitch stays below the window
    key_n[2] = 1'b0; repeat (3) @(negedge CLK);
    key_n[2] = 1'b1; repeat (HOLD) @(negedge CLK);
    chk("glitch.pulses", pulse2, 1);
    chk("glitch.st", {30'd0, state_o}, 32'd1);

    press(4'b1000, 16'h0000, "clr0");

    // full entry
    press(4'b0001, 16'h1234, "a_lo");
    press(4'b0010, 16'hABCD, "a_hi");
    press(4'b0100, 16'h0000, "to_b");
    press(4'b0001, 16'h0005, "b_lo");
    press(4'b0010, 16'hFFFF, "b_hi");
    press(4'b0100, 16'h0000, "to_op");
    press(4'b0001, 16'h0003, "op");
    press(4'b0100, 16'h0000, "issue");
    chk("full.a",  opif.porta, 32'hABCD1234);
    chk("full.b",  opif.portb, 32'hFFFF0005);
    chk("full.op", {28'd0, opif.aluop}, 32'h3);
    chk("full.v",  {31'd0, opif.op_valid}, 32'h1);

    // ISSUE holds while consumer stalls, and ignores entry keys
    repeat (10) @(negedge CLK);
    press(4'b0001, 16'h5555, "stall_k0");
    press(4'b0010, 16'h6666, "stall_k1");
    press(4'b0100, 16'h7777, "stall_k2");
    chk("stall.a", opif.porta, 32'hABCD1234);

    opif.op_ready = 1'b1;
    waited = 0;
    while (state_o != 2'd0 && waited < 10) begin
      @(negedge CLK); waited++;
    end
    opif.op_ready = 1'b0;
    m_st = 2'd0;
    chk("hs.st", {30'd0, state_o}, 32'd0);
    chk("hs.v",  {31'd0, opif.op_valid}, 32'd0);
    chk("hs.a",  opif.porta, 32'hABCD1234);
    chk("hs.b",  opif.portb, 32'hFFFF0005);
    chk("hs.op", {28'd0, opif.aluop}, 32'h3);

    // repeat issue with three KEY2 presses, then clear from ISSUE
    press(4'b0100, 16'h0000, "re1");
    press(4'b0100, 16'h0000, "re2");
    press(4'b0100, 16'h0000, "re3");
    press(4'b1000, 16'h0000, "clr_issue");

    // same-cycle KEY0 + KEY2 in ENTER_A
    press(4'b0101, 16'h00FF, "k0k2");
    chk("k0k2.a", opif.porta, 32'h000000FF);

    // async reset mid-debounce, with KEY0 held through reset release
    sw = 16'hBEEF;
    key_n[0] = 1'b0;
    repeat (3) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("arst.a",  opif.porta, 32'h0);
    chk("arst.st", {30'd0, state_o}, 32'd0);
    chk("arst.v",  {31'd0, opif.op_valid}, 32'd0);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    model_reset();
    repeat (20) @(negedge CLK);
    chk("held.a", opif.porta, 32'h0);
    key_n[0] = 1'b1;
    repeat (HOLD) @(negedge CLK);
    press(4'b0001, 16'hBEEF, "after_held");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

endmodule
